// File: rtl/voice_allocator_pkg.sv
// Shared types for the polyphonic voice allocator: slot/FSM state encodings,
// scan candidate ranking and the note-event record at default widths.
package audio_voice_pkg;

    localparam int DEF_INC_W  = 21;
    localparam int DEF_NOTE_W = 7;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_ACTIVE  = 2'd1,
        SLOT_RELEASE = 2'd2
    } slot_state_e;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_SCAN   = 2'd1,
        FSM_COMMIT = 2'd2
    } fsm_state_e;

    // Higher value wins during the scan; equal values fall back to age or index.
    typedef enum logic [1:0] {
        CAND_STEAL   = 2'd0,
        CAND_RELEASE = 2'd1,
        CAND_FREE    = 2'd2,
        CAND_MATCH   = 2'd3
    } cand_class_e;

    typedef struct packed {
        logic                  on;
        logic [DEF_NOTE_W-1:0] note;
        logic [DEF_INC_W-1:0]  increment;
        logic [3:0]            voice_select;
    } voice_event_t;

endpackage

// File: rtl/voice_allocator_slot.sv
// One oscillator slot: holds note, stamp, increment and select, and runs its
// own release countdown. A commit write always overrides a same-cycle expiry.
module voice_slot
    import audio_voice_pkg::*;
#(
    parameter int INC_W   = DEF_INC_W,
    parameter int NOTE_W  = DEF_NOTE_W,
    parameter int AGE_W   = 8,
    parameter int REL_LEN = 4800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_on,
    input  logic              wr_off,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [INC_W-1:0]  wr_inc,
    input  logic [3:0]        wr_sel,
    input  logic [AGE_W-1:0]  wr_stamp,
    output slot_state_e       state,
    output logic [NOTE_W-1:0] note,
    output logic [AGE_W-1:0]  stamp,
    output logic [INC_W-1:0]  inc,
    output logic [3:0]        sel
);

    localparam int CNT_W = (REL_LEN > 1) ? $clog2(REL_LEN) : 1;

    slot_state_e       state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [AGE_W-1:0]  stamp_q, stamp_d;
    logic [INC_W-1:0]  inc_q, inc_d;
    logic [3:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        stamp_d = stamp_q;
        inc_d   = inc_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (state_q == SLOT_RELEASE) begin
            if (cnt_q == '0) begin
                state_d = SLOT_FREE;
                inc_d   = '0;
                sel_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (wr_on) begin
            state_d = SLOT_ACTIVE;
            note_d  = wr_note;
            stamp_d = wr_stamp;
            inc_d   = wr_inc;
            sel_d   = wr_sel;
        end else if (wr_off) begin
            state_d = SLOT_RELEASE;
            cnt_d   = CNT_W'(REL_LEN - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_FREE;
            note_q  <= '0;
            stamp_q <= '0;
            inc_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            stamp_q <= stamp_d;
            inc_q   <= inc_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign note  = note_q;
    assign stamp = stamp_q;
    assign inc   = inc_q;
    assign sel   = sel_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note events, scans slots one per cycle,
// then commits to one slot. Define VOICE_STEAL_EN to steal the oldest ACTIVE slot.
module voice_allocator
    import audio_voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int INC_W      = DEF_INC_W,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int REL_LEN    = 4800,
    parameter int AGE_W      = 8
) (
    input  logic                        sample_clock,
    input  logic                        resetn,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [NOTE_W-1:0]           ev_note,
    input  logic [INC_W-1:0]            ev_increment,
    input  logic [3:0]                  ev_voice_select,
    output logic [NUM_VOICES*INC_W-1:0] voice_increment,
    output logic [NUM_VOICES*4-1:0]     voice_select,
    output logic [NUM_VOICES-1:0]       voice_gate,
    output logic                        ev_dropped
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    fsm_state_e        state_q, state_d;
    logic              ev_ready_q, ev_ready_d;
    logic              ev_dropped_q, ev_dropped_d;
    logic              ev_on_q, ev_on_d;
    logic [NOTE_W-1:0] ev_note_q, ev_note_d;
    logic [INC_W-1:0]  ev_inc_q, ev_inc_d;
    logic [3:0]        ev_sel_q, ev_sel_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    cand_class_e       best_class_q, best_class_d;
    logic [AGE_W-1:0]  best_age_q, best_age_d;
    logic              found_q, found_d;
    logic [AGE_W-1:0]  seq_q, seq_d;

    slot_state_e       slot_state [NUM_VOICES];
    logic [NOTE_W-1:0] slot_note  [NUM_VOICES];
    logic [AGE_W-1:0]  slot_stamp [NUM_VOICES];
    logic [INC_W-1:0]  slot_inc   [NUM_VOICES];
    logic [3:0]        slot_sel   [NUM_VOICES];
    logic [NUM_VOICES-1:0] wr_on, wr_off;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot #(
            .INC_W  (INC_W),
            .NOTE_W (NOTE_W),
            .AGE_W  (AGE_W),
            .REL_LEN(REL_LEN)
        ) u_slot (
            .clk     (sample_clock),
            .rst_n   (resetn),
            .wr_on   (wr_on[i]),
            .wr_off  (wr_off[i]),
            .wr_note (ev_note_q),
            .wr_inc  (ev_inc_q),
            .wr_sel  (ev_sel_q),
            .wr_stamp(seq_q),
            .state   (slot_state[i]),
            .note    (slot_note[i]),
            .stamp   (slot_stamp[i]),
            .inc     (slot_inc[i]),
            .sel     (slot_sel[i])
        );
        assign voice_increment[i*INC_W +: INC_W] = slot_inc[i];
        assign voice_select[i*4 +: 4]            = slot_sel[i];
        assign voice_gate[i]                     = (slot_state[i] == SLOT_ACTIVE);
    end

    slot_state_e      cur_state;
    logic             cur_match;
    logic [AGE_W-1:0] cur_age;
    logic             cand_valid;
    cand_class_e      cand_class;
    logic             cand_better;

    // Rank the slot under the scan index against the best candidate so far.
    always_comb begin
        cur_state  = slot_state[scan_idx_q];
        cur_match  = (slot_note[scan_idx_q] == ev_note_q);
        cur_age    = seq_q - slot_stamp[scan_idx_q];
        cand_valid = 1'b0;
        cand_class = CAND_STEAL;
        if (cur_state == SLOT_ACTIVE && cur_match) begin
            cand_valid = 1'b1;
            cand_class = CAND_MATCH;
        end else if (ev_on_q) begin
            if (cur_state == SLOT_FREE) begin
                cand_valid = 1'b1;
                cand_class = CAND_FREE;
            end else if (cur_state == SLOT_RELEASE) begin
                cand_valid = 1'b1;
                cand_class = CAND_RELEASE;
            end else begin
`ifdef VOICE_STEAL_EN
                cand_valid = 1'b1;
                cand_class = CAND_STEAL;
`else
                cand_valid = 1'b0;
`endif
            end
        end
        cand_better = cand_valid &&
                      (!found_q || (cand_class > best_class_q) ||
                       ((cand_class == best_class_q) &&
                        (cand_class == CAND_RELEASE || cand_class == CAND_STEAL) &&
                        (cur_age > best_age_q)));
    end

    always_comb begin
        state_d      = state_q;
        ev_ready_d   = ev_ready_q;
        ev_dropped_d = 1'b0;
        ev_on_d      = ev_on_q;
        ev_note_d    = ev_note_q;
        ev_inc_d     = ev_inc_q;
        ev_sel_d     = ev_sel_q;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_class_d = best_class_q;
        best_age_d   = best_age_q;
        found_d      = found_q;
        seq_d        = seq_q;
        wr_on        = '0;
        wr_off       = '0;
        case (state_q)
            FSM_IDLE: begin
                ev_ready_d = 1'b1;
                if (ev_valid && ev_ready_q) begin
                    ev_on_d    = ev_on;
                    ev_note_d  = ev_note;
                    ev_inc_d   = ev_increment;
                    ev_sel_d   = ev_voice_select;
                    scan_idx_d = '0;
                    found_d    = 1'b0;
                    ev_ready_d = 1'b0;
                    state_d    = FSM_SCAN;
                end
            end
            FSM_SCAN: begin
                ev_ready_d = 1'b0;
                if (cand_better) begin
                    found_d      = 1'b1;
                    best_idx_d   = scan_idx_q;
                    best_class_d = cand_class;
                    best_age_d   = cur_age;
                end
                if (scan_idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    ev_dropped_d = !found_d;
                    state_d      = FSM_COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            FSM_COMMIT: begin
                if (found_q) begin
                    wr_on[best_idx_q]  = ev_on_q;
                    wr_off[best_idx_q] = !ev_on_q;
                    if (ev_on_q) begin
                        seq_d = seq_q + 1'b1;
                    end
                end
                ev_ready_d = 1'b1;
                state_d    = FSM_IDLE;
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
    end

    always_ff @(posedge sample_clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= FSM_IDLE;
            ev_ready_q   <= 1'b0;
            ev_dropped_q <= 1'b0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= '0;
            ev_inc_q     <= '0;
            ev_sel_q     <= '0;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_class_q <= CAND_STEAL;
            best_age_q   <= '0;
            found_q      <= 1'b0;
            seq_q        <= '0;
        end else begin
            state_q      <= state_d;
            ev_ready_q   <= ev_ready_d;
            ev_dropped_q <= ev_dropped_d;
            ev_on_q      <= ev_on_d;
            ev_note_q    <= ev_note_d;
            ev_inc_q     <= ev_inc_d;
            ev_sel_q     <= ev_sel_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_class_q <= best_class_d;
            best_age_q   <= best_age_d;
            found_q      <= found_d;
            seq_q        <= seq_d;
        end
    end

    assign ev_ready   = ev_ready_q;
    assign ev_dropped = ev_dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: reset, allocation, release countdown,
// retrigger, steal/drop, unmatched note-off and reset during a scan.
module tb_voice_allocator;

    localparam int NV      = 4;
    localparam int INC_W   = 21;
    localparam int NOTE_W  = 7;
    localparam int REL_LEN = 24;
    localparam int AGE_W   = 8;

    logic                   sample_clock = 1'b0;
    logic                   resetn = 1'b0;
    logic                   ev_valid = 1'b0;
    logic                   ev_ready;
    logic                   ev_on = 1'b0;
    logic [NOTE_W-1:0]      ev_note = '0;
    logic [INC_W-1:0]       ev_increment = '0;
    logic [3:0]             ev_voice_select = '0;
    logic [NV*INC_W-1:0]    voice_increment;
    logic [NV*4-1:0]        voice_select;
    logic [NV-1:0]          voice_gate;
    logic                   ev_dropped;

    int vectors = 0;
    int miscompares = 0;
    int drop_cnt;
    int rdy_low_cnt;
    logic [NV-1:0] gate_and;

    voice_allocator #(
        .NUM_VOICES(NV),
        .INC_W     (INC_W),
        .NOTE_W    (NOTE_W),
        .REL_LEN   (REL_LEN),
        .AGE_W     (AGE_W)
    ) dut (
        .sample_clock   (sample_clock),
        .resetn         (resetn),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_on          (ev_on),
        .ev_note        (ev_note),
        .ev_increment   (ev_increment),
        .ev_voice_select(ev_voice_select),
        .voice_increment(voice_increment),
        .voice_select   (voice_select),
        .voice_gate     (voice_gate),
        .ev_dropped     (ev_dropped)
    );

    always #5 sample_clock = ~sample_clock;

    function automatic logic [INC_W-1:0] inc_of(input int i);
        return voice_increment[i*INC_W +: INC_W];
    endfunction

    function automatic logic [3:0] sel_of(input int i);
        return voice_select[i*4 +: 4];
    endfunction

    task automatic apply_reset();
        @(negedge sample_clock);
        resetn   = 1'b0;
        ev_valid = 1'b0;
        repeat (2) @(negedge sample_clock);
        resetn = 1'b1;
        @(negedge sample_clock);
    endtask

    // Handshake one event, then follow it through scan and commit.
    task automatic send(input logic on, input logic [NOTE_W-1:0] note,
                        input logic [INC_W-1:0] inc, input logic [3:0] sel);
        int n;
        n = 0;
        while (ev_ready !== 1'b1 && n < 50) begin
            @(negedge sample_clock);
            n++;
        end
        if (ev_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_ready_timeout: ev_ready=%b, required 1", ev_ready);
        end
        ev_on           = on;
        ev_note         = note;
        ev_increment    = inc;
        ev_voice_select = sel;
        ev_valid        = 1'b1;
        @(negedge sample_clock);
        ev_valid    = 1'b0;
        drop_cnt    = 0;
        rdy_low_cnt = 0;
        gate_and    = voice_gate;
        repeat (NV + 1) begin
            if (ev_ready === 1'b0) rdy_low_cnt++;
            if (ev_dropped === 1'b1) drop_cnt++;
            gate_and &= voice_gate;
            @(negedge sample_clock);
        end
        gate_and &= voice_gate;
    endtask

    task automatic play_four();
        send(1'b1, 7'd60, 21'h01000, 4'b0001);
        send(1'b1, 7'd62, 21'h01100, 4'b0010);
        send(1'b1, 7'd64, 21'h01200, 4'b0100);
        send(1'b1, 7'd67, 21'h01300, 4'b1000);
    endtask

    task automatic test_reset();
        @(negedge sample_clock);
        resetn = 1'b0;
        #1;
        vectors++;
        if (voice_gate !== '0 || voice_increment !== '0 || voice_select !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: gate=%h inc=%h sel=%h, required all 0",
                     voice_gate, voice_increment, voice_select);
        end
        vectors++;
        if (ev_ready !== 1'b0 || ev_dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready=%b dropped=%b, required 0/0", ev_ready, ev_dropped);
        end
        @(negedge sample_clock);
        resetn = 1'b1;
        @(negedge sample_clock);
        vectors++;
        if (ev_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: ready=%b, required 1", ev_ready);
        end
    endtask

    task automatic test_first_note();
        apply_reset();
        send(1'b1, 7'd60, 21'h01000, 4'b0001);
        vectors++;
        if (rdy_low_cnt !== NV + 1) begin
            miscompares++;
            $display("FAIL first_ready_low_cycles: got %0d, required %0d", rdy_low_cnt, NV + 1);
        end
        vectors++;
        if (voice_gate !== 4'b0001) begin
            miscompares++;
            $display("FAIL first_gate: got %b, required 0001", voice_gate);
        end
        vectors++;
        if (inc_of(0) !== 21'h01000 || sel_of(0) !== 4'b0001) begin
            miscompares++;
            $display("FAIL first_slot0: inc=%h sel=%b, required 01000/0001", inc_of(0), sel_of(0));
        end
        vectors++;
        if ((voice_increment >> INC_W) !== '0 || (voice_select >> 4) !== '0) begin
            miscompares++;
            $display("FAIL first_others: inc=%h sel=%h, required upper slots 0",
                     voice_increment, voice_select);
        end
        vectors++;
        if (ev_ready !== 1'b1 || drop_cnt !== 0) begin
            miscompares++;
            $display("FAIL first_ctrl: ready=%b drops=%0d, required 1/0", ev_ready, drop_cnt);
        end
    endtask

    task automatic test_release();
        int n;
        apply_reset();
        play_four();
        vectors++;
        if (voice_gate !== 4'b1111) begin
            miscompares++;
            $display("FAIL rel_four_gate: got %b, required 1111", voice_gate);
        end
        send(1'b0, 7'd62, 21'h0, 4'b0000);
        vectors++;
        if (voice_gate !== 4'b1101 || drop_cnt !== 0) begin
            miscompares++;
            $display("FAIL rel_gate_off: gate=%b drops=%0d, required 1101/0", voice_gate, drop_cnt);
        end
        n = 0;
        while (inc_of(1) === 21'h01100 && n < REL_LEN + 10) begin
            n++;
            @(negedge sample_clock);
        end
        vectors++;
        if (n !== REL_LEN) begin
            miscompares++;
            $display("FAIL rel_hold_cycles: got %0d, required %0d", n, REL_LEN);
        end
        vectors++;
        if (inc_of(1) !== '0 || sel_of(1) !== 4'b0000 || voice_gate !== 4'b1101) begin
            miscompares++;
            $display("FAIL rel_expired: inc=%h sel=%b gate=%b, required 0/0000/1101",
                     inc_of(1), sel_of(1), voice_gate);
        end
        vectors++;
        if (inc_of(2) !== 21'h01200 || sel_of(3) !== 4'b1000) begin
            miscompares++;
            $display("FAIL rel_neighbours: inc2=%h sel3=%b, required 01200/1000", inc_of(2), sel_of(3));
        end
        send(1'b1, 7'd70, 21'h01700, 4'b0011);
        vectors++;
        if (voice_gate !== 4'b1111 || inc_of(1) !== 21'h01700) begin
            miscompares++;
            $display("FAIL rel_reuse: gate=%b inc1=%h, required 1111/01700", voice_gate, inc_of(1));
        end
    endtask

    task automatic test_retrigger();
        apply_reset();
        send(1'b1, 7'd60, 21'h01000, 4'b0001);
        send(1'b1, 7'd60, 21'h02000, 4'b0010);
        vectors++;
        if (gate_and[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL retrig_gate_glitch: gate0 min=%b, required 1", gate_and[0]);
        end
        vectors++;
        if (voice_gate !== 4'b0001 || inc_of(0) !== 21'h02000 || sel_of(0) !== 4'b0010) begin
            miscompares++;
            $display("FAIL retrig_slot0: gate=%b inc=%h sel=%b, required 0001/02000/0010",
                     voice_gate, inc_of(0), sel_of(0));
        end
    endtask

    task automatic test_steal();
        apply_reset();
        play_four();
        send(1'b1, 7'd72, 21'h03000, 4'b0101);
`ifdef VOICE_STEAL_EN
        vectors++;
        if (drop_cnt !== 0 || inc_of(0) !== 21'h03000 || sel_of(0) !== 4'b0101) begin
            miscompares++;
            $display("FAIL steal_slot0: drops=%0d inc=%h sel=%b, required 0/03000/0101",
                     drop_cnt, inc_of(0), sel_of(0));
        end
        vectors++;
        if (voice_gate !== 4'b1111 || inc_of(1) !== 21'h01100 || inc_of(3) !== 21'h01300) begin
            miscompares++;
            $display("FAIL steal_others: gate=%b inc1=%h inc3=%h, required 1111/01100/01300",
                     voice_gate, inc_of(1), inc_of(3));
        end
`else
        vectors++;
        if (drop_cnt !== 1) begin
            miscompares++;
            $display("FAIL nosteal_drop_pulses: got %0d, required 1", drop_cnt);
        end
        vectors++;
        if (voice_gate !== 4'b1111 || inc_of(0) !== 21'h01000 || sel_of(0) !== 4'b0001 ||
            inc_of(3) !== 21'h01300) begin
            miscompares++;
            $display("FAIL nosteal_unchanged: gate=%b inc0=%h sel0=%b inc3=%h, required 1111/01000/0001/01300",
                     voice_gate, inc_of(0), sel_of(0), inc_of(3));
        end
`endif
    endtask

    task automatic test_off_unknown();
        logic [NV*INC_W-1:0] inc_snap;
        logic [NV*4-1:0]     sel_snap;
        logic [NV-1:0]       gate_snap;
        inc_snap  = voice_increment;
        sel_snap  = voice_select;
        gate_snap = voice_gate;
        send(1'b0, 7'd50, 21'h0, 4'b0000);
        vectors++;
        if (drop_cnt !== 1 || ev_dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL offunk_drop: pulses=%0d after=%b, required 1/0", drop_cnt, ev_dropped);
        end
        vectors++;
        if (voice_increment !== inc_snap || voice_select !== sel_snap || voice_gate !== gate_snap) begin
            miscompares++;
            $display("FAIL offunk_unchanged: gate=%b inc=%h, required gate=%b inc=%h",
                     voice_gate, voice_increment, gate_snap, inc_snap);
        end
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        send(1'b1, 7'd60, 21'h01000, 4'b0001);
        ev_on           = 1'b1;
        ev_note         = 7'd62;
        ev_increment    = 21'h01100;
        ev_voice_select = 4'b0010;
        ev_valid        = 1'b1;
        @(negedge sample_clock);
        ev_valid = 1'b0;
        repeat (2) @(negedge sample_clock);
        resetn = 1'b0;
        #1;
        vectors++;
        if (voice_gate !== '0 || voice_increment !== '0 || voice_select !== '0 ||
            ev_ready !== 1'b0 || ev_dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL midscan_reset: gate=%b inc=%h sel=%h ready=%b drop=%b, required all 0",
                     voice_gate, voice_increment, voice_select, ev_ready, ev_dropped);
        end
        repeat (2) @(negedge sample_clock);
        resetn = 1'b1;
        @(negedge sample_clock);
        send(1'b1, 7'd64, 21'h04000, 4'b0100);
        vectors++;
        if (voice_gate !== 4'b0001 || inc_of(0) !== 21'h04000 || (voice_increment >> INC_W) !== '0) begin
            miscompares++;
            $display("FAIL midscan_fresh: gate=%b inc=%h, required 0001 with slot0 04000",
                     voice_gate, voice_increment);
        end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_release();
        test_retrigger();
        test_steal();
        test_off_unknown();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
